// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and helpers for the elastic skid pipeline stage
package pipe_pkg;

    // Width of the exception bundle carried next to every payload.
    localparam int EXC_W = 6;

    typedef logic [EXC_W-1:0] ExceptinPipeType;

    // Slot occupancy: EMPTY (nothing held), BUSY (main only), FULL (main + skid).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Saturating increment for the 32-bit performance counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// rtl/pipe_skid_slot.sv - one skid slot: main/skid registers behind a valid/ready handshake
//
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   flush           drop every held entry on the next edge; input in this cycle is ignored
//   in_valid/ready  upstream handshake; in_ready is a flop, independent of out_ready
//   in_data         payload entering the slot
//   out_valid/ready downstream handshake
//   out_data        payload from the main register
module pipe_skid_slot #(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    import pipe_pkg::*;

    skid_state_t  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         ready_q;
    logic         accept;
    logic         drain;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_ready  = ready_q;

    // The flush cycle never captures new input; an outgoing transfer still happens.
    assign accept = in_valid && ready_q && !flush;
    assign drain  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = BUSY;
                    main_d  = in_data;
                end
            end
            BUSY: begin
                if (accept && !drain) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (accept && drain) begin
                    main_d = in_data;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // ready_q is low here, so accept cannot be set alongside drain.
                if (drain) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            // Registered copy of (state != FULL), so it tracks state_q exactly.
            ready_q <= (state_d != FULL);
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - elastic pipeline register built from a chain of skid slots
//
// Optional feature macro: PIPE_SKID_PERF_EN (enables stall_cnt / bubble_cnt counters).
// Ports:
//   clk, rst, flush       clock, synchronous active-high reset, synchronous kill
//   in_valid/ready/data/exc   upstream payload handshake
//   out_valid/ready/data/exc  downstream payload handshake
//   stall_cnt             cycles with out_valid=1 and out_ready=0 (0 when perf disabled)
//   bubble_cnt            cycles with out_valid=0 (0 when perf disabled)
module pipe_skid_stage #(
    parameter int DATA_W = 32,
    parameter int EXC_W  = pipe_pkg::EXC_W,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EXC_W-1:0]  in_exc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [EXC_W-1:0]  out_exc,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
);
    import pipe_pkg::*;

    localparam int W = DATA_W + EXC_W;

    // link index k is the boundary in front of slot k; index STAGES is the stage output.
    logic [STAGES:0]        link_valid;
    logic [STAGES:0]        link_ready;
    logic [STAGES:0][W-1:0] link_data;

    assign link_valid[0]      = in_valid;
    assign link_data[0]       = {in_exc, in_data};
    assign in_ready           = link_ready[0];
    assign link_ready[STAGES] = out_ready;
    assign out_valid          = link_valid[STAGES];
    assign {out_exc, out_data} = link_data[STAGES];

    for (genvar g = 0; g < STAGES; g++) begin : g_slot
        pipe_skid_slot #(
            .W (W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (link_valid[g]),
            .in_ready  (link_ready[g]),
            .in_data   (link_data[g]),
            .out_valid (link_valid[g+1]),
            .out_ready (link_ready[g+1]),
            .out_data  (link_data[g+1])
        );
    end

`ifdef PIPE_SKID_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] bubble_q, bubble_d;

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (out_valid && !out_ready) begin
            stall_d = sat_inc(stall_q);
        end
        if (!out_valid) begin
            bubble_d = sat_inc(bubble_q);
        end
    end

    // Only reset clears the counters; flush leaves them running.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = 32'h0;
    assign bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - randomized self-checking bench for pipe_skid_stage (STAGES=1 and 3)
module tb_pipe_skid_stage;

    localparam int DW = 32;
    localparam int EW = 6;
    localparam int PW = DW + EW;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [EW-1:0] in_exc;
    logic          out_ready;

    logic          ir [2];
    logic          ov [2];
    logic [DW-1:0] od [2];
    logic [EW-1:0] oe [2];
    logic [31:0]   sc [2];
    logic [31:0]   bc [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(DW), .EXC_W(EW), .STAGES(1)) u_dut_s1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data), .in_exc(in_exc),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_exc(oe[0]),
        .stall_cnt(sc[0]), .bubble_cnt(bc[0])
    );

    pipe_skid_stage #(.DATA_W(DW), .EXC_W(EW), .STAGES(3)) u_dut_s3 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data), .in_exc(in_exc),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_exc(oe[1]),
        .stall_cnt(sc[1]), .bubble_cnt(bc[1])
    );

    // Reference: each slot is a 2-deep FIFO; ready = room left, valid = non-empty.
    int            nst [2] = '{1, 3};
    int            cnt [2][4];
    logic [PW-1:0] fifo [2][4][2];
    logic [31:0]   m_stall [2];
    logic [31:0]   m_bubble [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input int idx);
        int            n;
        logic          rdy [4];
        logic          ofire [4];
        logic [PW-1:0] front [4];
        logic          mv;
        logic          push;
        n = nst[idx];
        for (int k = 0; k < 4; k++) begin
            rdy[k]   = cnt[idx][k] < 2;
            front[k] = fifo[idx][k][0];
            ofire[k] = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            ofire[k] = (cnt[idx][k] > 0) && ((k == n - 1) ? out_ready : rdy[k+1]);
        end
        mv = cnt[idx][n-1] > 0;
        if (rst) begin
            m_stall[idx]  = 0;
            m_bubble[idx] = 0;
        end else begin
            if (mv && !out_ready && m_stall[idx] != 32'hFFFF_FFFF) m_stall[idx]++;
            if (!mv && m_bubble[idx] != 32'hFFFF_FFFF) m_bubble[idx]++;
        end
        if (rst || flush) begin
            for (int k = 0; k < 4; k++) cnt[idx][k] = 0;
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (ofire[k]) begin
                fifo[idx][k][0] = fifo[idx][k][1];
                cnt[idx][k]--;
            end
            push = (k == 0) ? (in_valid && rdy[0]) : ofire[k-1];
            if (push) begin
                fifo[idx][k][cnt[idx][k]] = (k == 0) ? {in_exc, in_data} : front[k-1];
                cnt[idx][k]++;
            end
        end
    endtask

    task automatic check_outputs(input int idx, input logic after_rst);
        string p;
        int    n;
        logic  ev;
        p  = (idx == 0) ? "s1" : "s3";
        n  = nst[idx];
        ev = cnt[idx][n-1] > 0;
        chk({p, "_in_ready"}, 64'(ir[idx]), 64'(cnt[idx][0] < 2));
        chk({p, "_out_valid"}, 64'(ov[idx]), 64'(ev));
        if (ev) begin
            chk({p, "_out_data"}, 64'(od[idx]), 64'(fifo[idx][n-1][0][DW-1:0]));
            chk({p, "_out_exc"}, 64'(oe[idx]), 64'(fifo[idx][n-1][0][PW-1:DW]));
        end
        if (after_rst) begin
            chk({p, "_rst_data"}, 64'(od[idx]), 64'(0));
            chk({p, "_rst_exc"}, 64'(oe[idx]), 64'(0));
        end
`ifdef PIPE_SKID_PERF_EN
        chk({p, "_stall_cnt"}, 64'(sc[idx]), 64'(m_stall[idx]));
        chk({p, "_bubble_cnt"}, 64'(bc[idx]), 64'(m_bubble[idx]));
`else
        chk({p, "_stall_cnt"}, 64'(sc[idx]), 64'(0));
        chk({p, "_bubble_cnt"}, 64'(bc[idx]), 64'(0));
`endif
    endtask

    // Present inputs for one clock edge, advance the model, then check after the edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic [EW-1:0] e,
                        input logic ordy, input logic fl, input logic rs);
        rst       = rs;
        flush     = fl;
        in_valid  = v;
        in_data   = d;
        in_exc    = e;
        out_ready = ordy;
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_outputs(0, rs);
        check_outputs(1, rs);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_stall[i]  = 0;
            m_bubble[i] = 0;
            for (int k = 0; k < 4; k++) begin
                cnt[i][k]     = 0;
                fifo[i][k][0] = '0;
                fifo[i][k][1] = '0;
            end
        end

        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);

        // Back-to-back stream with free downstream.
        step(1, 32'h1, 0, 1, 0, 0);
        step(1, 32'h2, 0, 1, 0, 0);
        step(1, 32'h3, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);

        // Two entries against a blocked downstream, then release.
        step(1, 32'hA, 0, 0, 0, 0);
        step(1, 32'hB, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0);

        // Exception bundle travels with its payload.
        step(1, 32'h55, 6'b000100, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);

        // Fill under back-pressure, then flush with a live input that must vanish.
        for (int i = 0; i < 8; i++) step(1, 32'h100 + i, 6'(i), 0, 0, 0);
        step(1, 32'hC, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0);

        // Stall then empty cycles for the counters; then reset mid-stream.
        step(0, 0, 0, 1, 0, 1);
        step(1, 32'h77, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 32'h200 + i, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic          v, ordy, fl, rs;
            logic [DW-1:0] d;
            logic [EW-1:0] e;
            v    = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 99) < 2);
            rs   = ($urandom_range(0, 199) < 1);
            d    = $urandom;
            e    = ($urandom_range(0, 1) == 1) ? EW'($urandom) : '0;
            step(v, d, e, ordy, fl, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
